// File: rtl/alu_seq.sv
// alu_seq: sequential ALU. Single-cycle logic/arith/shift/compare ops, plus
// a multi-cycle unsigned shift-add multiplier and restoring divider that share
// one double-width accumulator.
//
// state | meaning
// IDLE  | ready; accepts start, single-cycle ops complete here
// MUL   | shift-add multiply, one multiplier bit per clock
// DIV   | restoring divide, one quotient bit per clock
module alu_seq #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] s,
   output logic [WIDTH-1:0] hi,
   output logic             z,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

   state_t                 state_q, state_d;
   logic [WIDTH-1:0]       s_q, s_d, hi_q, hi_d, opnd_q, opnd_d;
   logic [2*WIDTH-1:0]     acc_q, acc_d;
   logic [SHW-1:0]         cnt_q, cnt_d;
   logic                   z_q, z_d, done_q, done_d;

   logic [SHW-1:0]         sh;
   logic signed [WIDTH-1:0] sra_v;
   logic [WIDTH-1:0]       alu_s, alu_hi;
   logic                   go_mul, go_div;
   logic [WIDTH:0]         mul_sum, div_trial;
   logic [2*WIDTH-1:0]     mul_next, div_next;

   // Single-cycle result decode; MULU and nonzero-divisor DIVU flag the FSM instead.
   always_comb begin
      sh     = a[SHW-1:0];
      sra_v  = $signed(b) >>> sh;
      alu_s  = '0;
      alu_hi = '0;
      go_mul = 1'b0;
      go_div = 1'b0;
      if (!op[4]) begin
         case (op[2:0])
            3'b000:  alu_s = a + b;
            3'b100:  alu_s = a - b;
            3'b001:  alu_s = a & b;
            3'b101:  alu_s = a | b;
            3'b010:  alu_s = a ^ b;
            3'b110:  alu_s = b << (WIDTH/2);
            3'b011:  if (!op[3]) alu_s = b << sh;
            3'b111:  alu_s = op[3] ? sra_v : (b >> sh);
            default: alu_s = '0;
         endcase
      end else begin
         case (op[3:0])
            4'b0000: go_mul = 1'b1;
            4'b0001: begin
               if (b == '0) begin
                  alu_s  = '1;
                  alu_hi = a;
               end else begin
                  go_div = 1'b1;
               end
            end
            4'b0010: alu_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'b0011: alu_s = {{(WIDTH-1){1'b0}}, (a < b)};
            default: alu_s = '0;
         endcase
      end
   end

   // One iteration of multiply (acc = {partial, multiplier}) and divide (acc = {rem, quotient}).
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
      div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
      if (!div_trial[WIDTH])
         div_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else
         div_next = {acc_q[2*WIDTH-2:0], 1'b0};
   end

   // Next-state and result logic; results hold while busy.
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      hi_d    = hi_q;
      opnd_d  = opnd_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (go_mul) begin
                  state_d = MUL;
                  acc_d   = {{WIDTH{1'b0}}, b};
                  opnd_d  = a;
                  cnt_d   = SHW'(WIDTH-1);
               end else if (go_div) begin
                  state_d = DIV;
                  acc_d   = {{WIDTH{1'b0}}, a};
                  opnd_d  = b;
                  cnt_d   = SHW'(WIDTH-1);
               end else begin
                  s_d    = alu_s;
                  hi_d   = alu_hi;
                  done_d = 1'b1;
               end
            end
         end
         MUL: begin
            acc_d = mul_next;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               s_d     = mul_next[WIDTH-1:0];
               hi_d    = mul_next[2*WIDTH-1:WIDTH];
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         DIV: begin
            acc_d = div_next;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               s_d     = div_next[WIDTH-1:0];
               hi_d    = div_next[2*WIDTH-1:WIDTH];
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      z_d = (s_d == '0);
   end

   // State and result registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         s_q     <= '0;
         hi_q    <= '0;
         z_q     <= 1'b1;
         done_q  <= 1'b0;
         opnd_q  <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         hi_q    <= hi_d;
         z_q     <= z_d;
         done_q  <= done_d;
         opnd_q  <= opnd_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign s    = s_q;
   assign hi   = hi_q;
   assign z    = z_q;
   assign done = done_q;
   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: scoreboard on the 32-bit instance, direct checks on a 16-bit instance.
module tb_alu_seq;

   localparam logic [4:0] ADD = 5'b00000, SUB = 5'b00100, AND_ = 5'b00001, OR_ = 5'b00101;
   localparam logic [4:0] XOR_ = 5'b00010, LUI = 5'b00110, SLL = 5'b00011, SRL = 5'b00111;
   localparam logic [4:0] SRA = 5'b01111, MULU = 5'b10000, DIVU = 5'b10001;
   localparam logic [4:0] SLT = 5'b10010, SLTU = 5'b10011;

   logic        clock = 1'b0;
   logic        reset, start;
   logic [4:0]  op;
   logic [31:0] a, b, s, hi;
   logic        z, busy, done;

   logic        start16;
   logic [4:0]  op16;
   logic [15:0] a16, b16, s16, hi16;
   logic        z16, busy16, done16;

   int n_checks = 0;
   int n_errors = 0;
   logic [64:0] sb[$];

   always #5 clock = ~clock;

   alu_seq #(.WIDTH(32), .SHW(5)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .s(s), .hi(hi), .z(z), .busy(busy), .done(done)
   );

   alu_seq #(.WIDTH(16), .SHW(4)) dut16 (
      .clock(clock), .reset(reset), .start(start16), .op(op16), .a(a16), .b(b16),
      .s(s16), .hi(hi16), .z(z16), .busy(busy16), .done(done16)
   );

   // Monitor: every done pulse must match the oldest expected result.
   always @(negedge clock) begin
      logic [64:0] e;
      if (!reset && done) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_done s=%h hi=%h", s, hi);
         end else begin
            e = sb.pop_front();
            if ({s, hi, z} !== e) begin
               n_errors++;
               $display("FAIL result s/hi/z act=%h/%h/%b exp=%h/%h/%b",
                        s, hi, z, e[64:33], e[32:1], e[0]);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic issue(input logic [4:0] o, input logic [31:0] aa, input logic [31:0] bb,
                        input logic [31:0] es, input logic [31:0] eh, input bit push);
      start = 1'b1; op = o; a = aa; b = bb;
      if (push) sb.push_back({es, eh, (es == 32'h0)});
      step(1);
      start = 1'b0;
   endtask

   task automatic wait_done(input int max, output int n);
      n = 0;
      while (!done && n < max) begin
         step(1);
         n++;
      end
      if (!done) begin
         n_errors++;
         $display("FAIL wait_done timeout act=%0d cycles exp<%0d", n, max);
      end
   endtask

   task automatic run1(input logic [4:0] o, input logic [31:0] aa, input logic [31:0] bb,
                       input logic [31:0] es, input logic [31:0] eh);
      int n;
      issue(o, aa, bb, es, eh, 1'b1);
      wait_done(4, n);
      chk("single_latency", n, 0);
      step(1);
   endtask

   initial begin
      int n;
      reset = 1'b1; start = 1'b1; op = ADD; a = 32'd1; b = 32'd1;
      start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
      step(2);
      chk("rst_s", s, 0);
      chk("rst_hi", hi, 0);
      chk("rst_z", {31'b0, z}, 1);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_done", {31'b0, done}, 0);
      start = 1'b0;
      step(1);
      reset = 1'b0;
      step(1);

      run1(ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0);
      chk("done_single_pulse", {31'b0, done}, 0);
      run1(SRA, 32'h4, 32'h8000_0000, 32'hF800_0000, 32'h0);
      run1(SUB, 32'h3, 32'h5, 32'hFFFF_FFFE, 32'h0);
      run1(AND_, 32'hF0F0, 32'hFF00, 32'hF000, 32'h0);
      run1(OR_, 32'hF0F0, 32'hFF00, 32'hFFF0, 32'h0);
      run1(XOR_, 32'hF0F0, 32'hFF00, 32'h0FF0, 32'h0);
      run1(LUI, 32'h0, 32'h0000_1234, 32'h1234_0000, 32'h0);
      run1(5'b01000, 32'h2, 32'h2, 32'h4, 32'h0);
      run1(SLL, 32'h24, 32'h1, 32'h10, 32'h0);
      run1(SRL, 32'h4, 32'h8000_0000, 32'h0800_0000, 32'h0);
      run1(5'b01011, 32'h4, 32'h8, 32'h0, 32'h0);
      run1(5'b10100, 32'h4, 32'h8, 32'h0, 32'h0);
      run1(SLTU, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0);
      run1(SLT, 32'h1, 32'h7FFF_FFFF, 32'h1, 32'h0);

      // MULU max*max, results must hold while busy
      issue(MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1);
      a = 32'h0; b = 32'h0; op = ADD;
      step(10);
      chk("mul_busy", {31'b0, busy}, 1);
      chk("mul_hold_s", s, 32'h1);
      chk("mul_hold_done", {31'b0, done}, 0);
      wait_done(40, n);
      chk("mul_cycles", n + 10, 32);
      chk("mul_busy_end", {31'b0, busy}, 0);
      step(1);
      chk("mul_done_pulse", {31'b0, done}, 0);

      // DIVU 100/7 then DIVU by zero issued in the done cycle
      issue(DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 1'b1);
      wait_done(40, n);
      chk("div_cycles", n, 32);
      issue(DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
      wait_done(4, n);
      chk("div0_latency", n, 0);
      chk("div0_busy", {31'b0, busy}, 0);
      step(1);

      // start while busy is ignored
      issue(MULU, 32'd3, 32'd5, 32'd15, 32'd0, 1'b1);
      step(4);
      start = 1'b1; op = ADD; a = 32'd1; b = 32'd1;
      step(2);
      start = 1'b0; a = 32'h0; b = 32'h0;
      wait_done(40, n);
      chk("ignored_start_cycles", n, 26);
      step(1);

      // reset at cycle 10 of a divide aborts it
      issue(DIVU, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0);
      step(9);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      chk("abort_s", s, 0);
      chk("abort_hi", hi, 0);
      chk("abort_z", {31'b0, z}, 1);
      chk("abort_busy", {31'b0, busy}, 0);
      chk("abort_done", {31'b0, done}, 0);
      step(40);
      run1(SLT, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h0);

      // 16-bit instance
      start16 = 1'b1; op16 = MULU; a16 = 16'hFFFF; b16 = 16'hFFFF;
      step(1);
      start16 = 1'b0;
      n = 0;
      while (!done16 && n < 40) begin
         step(1);
         n++;
      end
      chk("w16_mul_cycles", n, 16);
      chk("w16_mul_hi", {16'h0, hi16}, 32'hFFFE);
      chk("w16_mul_s", {16'h0, s16}, 32'h0001);
      step(1);
      start16 = 1'b1; op16 = LUI; a16 = 16'h0; b16 = 16'h00AB;
      step(1);
      start16 = 1'b0;
      chk("w16_lui_done", {31'b0, done16}, 1);
      chk("w16_lui_s", {16'h0, s16}, 32'hAB00);
      chk("w16_lui_hi", {16'h0, hi16}, 32'h0);

      step(5);
      chk("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32: datapath width; SHALL be an even number >= 8.
REQ-002 Parameter SHW, default 5: shift-amount width; SHALL equal log2(WIDTH).
REQ-003 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request strobe; sampled only when busy=0.
REQ-006 op  input  5  operation code, sampled together with start.
REQ-007 a, b  input  WIDTH each  operands, sampled together with start.
REQ-008 s  output  WIDTH  registered result; holds the quotient for DIVU and the low half of the product for MULU.
REQ-009 hi  output  WIDTH  registered high half for MULU, remainder for DIVU, 0 for all other ops.
REQ-010 z  output  1  registered; SHALL be 1 exactly when s==0.
REQ-011 busy  output  1  high while a multi-cycle op is executing.
REQ-012 done  output  1  one-cycle pulse; s, hi and z are valid from this cycle until the next accepted start.

Function
REQ-013 An accepted start is start=1 and busy=0 at a rising edge; start while busy=1 SHALL be ignored, with no queuing.
REQ-014 op[4]=0 selects the single-cycle ops, decoded on op[3:0] as listed in REQ-015 to REQ-019.
REQ-015 op[3:0]: x000 ADD a+b; x100 SUB a-b; x001 AND; x101 OR; x010 XOR; x110 LUI b<<(WIDTH/2).
REQ-016 op[3:0]: 0011 SLL b<<a[SHW-1:0]; 0111 SRL, logical; 1111 SRA, arithmetic; shift amounts SHALL use only a[SHW-1:0].
REQ-017 op[4]=1 ops: 10000 MULU, 10001 DIVU, 10010 SLT (signed a<b gives 1, else 0), 10011 SLTU (unsigned).
REQ-018 Any undefined op SHALL produce s=0, hi=0, z=1 as a single-cycle op.
REQ-019 All arithmetic SHALL be modulo 2^WIDTH; no carry or overflow output is provided.
REQ-020 States: IDLE, MUL, DIV; busy SHALL be 1 exactly in MUL or DIV.
REQ-021 Single-cycle op accepted at edge k: results registered at edge k, done=1 for the cycle after edge k, state stays IDLE.
REQ-022 MULU accepted at edge k: state goes IDLE->MUL; unsigned shift-add, one bit per edge on edges k+1..k+WIDTH.
REQ-023 At edge k+WIDTH the MULU result SHALL load as {hi,s}=a*b (2*WIDTH bits), with done=1 and the state back in IDLE.
REQ-024 DIVU with b!=0: state goes IDLE->DIV; restoring division, one bit per edge; s=a/b and hi=a%b at edge k+WIDTH, then done.
REQ-025 DIVU with b==0: no DIV state; at edge k s=all ones and hi=a, done the next cycle (single-cycle timing).
REQ-026 Operands SHALL be latched at acceptance; changes to a, b or op during busy SHALL NOT affect the result.
REQ-027 During busy, s, hi and z SHALL hold the previous result until completion.
REQ-028 A start present in the done cycle SHALL be accepted, giving back-to-back operation with no idle cycle.
REQ-029 done SHALL never be high for two consecutive cycles unless two operations are accepted back to back.

Reset
REQ-030 While reset=1 at an edge: state=IDLE, s=0, hi=0, z=1, busy=0, done=0, with reset having priority over start.
REQ-031 Reset during MUL or DIV SHALL abort the operation; no done pulse follows and the next op starts cleanly.

Verification
REQ-032 Single-cycle: ADD a=0xFFFFFFFF, b=1 -> s=0, z=1, done one cycle later; SRA b=0x80000000, a=4 -> s=0xF8000000.
REQ-033 Multiply: MULU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 32 cycles hi=0xFFFFFFFE, s=0x00000001, busy high 32 cycles, done single pulse.
REQ-034 Divide: DIVU a=100, b=7 -> s=14, hi=2 at cycle 32; DIVU a=5, b=0 -> s=0xFFFFFFFF, hi=5, done next cycle.
REQ-035 Ignored start: MULU 3*5, then start=1 with ADD 1+1 mid-operation -> that start is ignored, final s=15, hi=0.
REQ-036 Reset mid-operation: reset at cycle 10 of DIVU -> all outputs at reset values, no done; a following SLT a=-1, b=0 -> s=1.
REQ-037 Parameter check: WIDTH=16 with MULU 0xFFFF*0xFFFF -> hi=0xFFFE, s=0x0001 after 16 cycles; LUI b=0x00AB -> s=0xAB00.
